// File: rtl/sc_reg_psr_stack.sv
// Processor status register with masked per-flag writes and a LIFO of saved flag sets.
// State changes on the falling clock edge to line up with the rest of the datapath.
module sc_reg_psr_stack #(
    parameter int unsigned               DATAWIDTH_BUS    = 32,
    parameter int unsigned               NUM_FLAGS        = 4,
    parameter int unsigned               FLAG_LSB         = 20,
    parameter int unsigned               STACK_DEPTH      = 4,
    parameter int unsigned               PTR_WIDTH        = 2,
    parameter logic [DATAWIDTH_BUS-1:0]  DATA_REGGEN_INIT = '0
) (
    input  logic                     SC_RegPSRStack_CLOCK_50,
    input  logic                     SC_RegPSRStack_Reset_InHigh,
    input  logic                     SC_RegPSRStack_Write_InHigh,
    input  logic [NUM_FLAGS-1:0]     SC_RegPSRStack_WriteMask_InBUS,
    input  logic [NUM_FLAGS-1:0]     SC_RegPSRStack_Flags_InBUS,
    input  logic                     SC_RegPSRStack_Push_InHigh,
    input  logic                     SC_RegPSRStack_Pop_InHigh,
    input  logic                     SC_RegPSRStack_ClearErr_InHigh,
    output logic [NUM_FLAGS-1:0]     PSR_Flags_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] PSR_Word_OutBUS,
    output logic [PTR_WIDTH:0]       PSR_Depth_OutBUS,
    output logic                     PSR_Full_OutHigh,
    output logic                     PSR_Empty_OutHigh,
    output logic                     PSR_StackOvfErr_OutHigh,
    output logic                     PSR_StackUnfErr_OutHigh
);

    localparam logic [PTR_WIDTH:0]   FULL_DEPTH = (PTR_WIDTH+1)'(STACK_DEPTH);
    localparam logic [NUM_FLAGS-1:0] INIT_FLAGS = DATA_REGGEN_INIT[FLAG_LSB +: NUM_FLAGS];

    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] flags_next;
    logic [NUM_FLAGS-1:0] stack [STACK_DEPTH];
    logic [PTR_WIDTH:0]   depth;
    logic [PTR_WIDTH-1:0] push_idx;
    logic [PTR_WIDTH-1:0] top_idx;
    logic                 ovf_err;
    logic                 unf_err;
    logic                 do_push;
    logic                 do_pop;
    logic                 ovf_evt;
    logic                 unf_evt;

    assign PSR_Full_OutHigh  = (depth == FULL_DEPTH);
    assign PSR_Empty_OutHigh = (depth == '0);

    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        push_idx = depth[PTR_WIDTH-1:0];
        top_idx  = PTR_WIDTH'(depth - 1'b1);

        // Simultaneous push and pop cancel out: neither a stack move nor an error.
        if (SC_RegPSRStack_Push_InHigh && !SC_RegPSRStack_Pop_InHigh) begin
            do_push = !PSR_Full_OutHigh;
            ovf_evt = PSR_Full_OutHigh;
        end
        if (SC_RegPSRStack_Pop_InHigh && !SC_RegPSRStack_Push_InHigh) begin
            do_pop  = !PSR_Empty_OutHigh;
            unf_evt = PSR_Empty_OutHigh;
        end

        flags_next = flags;
        if (do_pop)
            flags_next = stack[top_idx];
        else if (SC_RegPSRStack_Write_InHigh)
            flags_next = (flags & ~SC_RegPSRStack_WriteMask_InBUS) |
                         (SC_RegPSRStack_Flags_InBUS & SC_RegPSRStack_WriteMask_InBUS);
    end

    always_ff @(negedge SC_RegPSRStack_CLOCK_50) begin
        if (SC_RegPSRStack_Reset_InHigh) begin
            flags   <= INIT_FLAGS;
            depth   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            flags <= flags_next;
            if (do_push)
                depth <= depth + 1'b1;
            else if (do_pop)
                depth <= depth - 1'b1;
            // A new error event beats a same-edge clear.
            if (ovf_evt)
                ovf_err <= 1'b1;
            else if (SC_RegPSRStack_ClearErr_InHigh)
                ovf_err <= 1'b0;
            if (unf_evt)
                unf_err <= 1'b1;
            else if (SC_RegPSRStack_ClearErr_InHigh)
                unf_err <= 1'b0;
        end
    end

    // Saved slot takes the pre-write flags; contents are not reset.
    always_ff @(negedge SC_RegPSRStack_CLOCK_50) begin
        if (!SC_RegPSRStack_Reset_InHigh && do_push)
            stack[push_idx] <= flags;
    end

    always_comb begin
        PSR_Word_OutBUS                        = '0;
        PSR_Word_OutBUS[FLAG_LSB +: NUM_FLAGS] = flags;
    end

    assign PSR_Flags_OutBUS        = flags;
    assign PSR_Depth_OutBUS        = depth;
    assign PSR_StackOvfErr_OutHigh = ovf_err;
    assign PSR_StackUnfErr_OutHigh = unf_err;

endmodule
